// File: rtl/fifo_pkg.sv
// Shared helpers for the stream FIFO family: pointer sizing, parameter legality and reset values.
package fifo_pkg;

    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_ALMOST_FULL  = 1'b0;

    // Pointer/level width: one extra bit over the address so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit thresholds_ok(input int unsigned depth,
                                         input int unsigned depth_log2,
                                         input int unsigned almost_full,
                                         input int unsigned almost_empty);
        return (depth == (32'(1) << depth_log2)) &&
               (ptr_width(depth) == depth_log2 + 1) &&
               (almost_full >= 1) && (almost_full <= depth) &&
               (almost_empty <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, contents never reset.
module fifo_ram #(
    parameter int unsigned p_width     = 32,
    parameter int unsigned p_depth     = 8,
    parameter int unsigned p_addr_bits = 3
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [p_addr_bits-1:0] wr_addr,
    input  logic [p_width-1:0]     wr_data,
    input  logic [p_addr_bits-1:0] rd_addr,
    output logic [p_width-1:0]     rd_data
);

    logic [p_width-1:0] mem [p_depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo_th.sv
// Valid/ready stream FIFO with level, almost-full/empty flags, high-watermark and flush.
// STREAM_FIFO_OREG_EN adds a registered output stage (one extra word of capacity).
module stream_fifo_th
    import fifo_pkg::*;
#(
    parameter int unsigned p_st_bits          = 32,
    parameter int unsigned p_fifo_length      = 8,
    parameter int unsigned p_fifo_length_log2 = 3,
    parameter int unsigned p_almost_full      = 6,
    parameter int unsigned p_almost_empty     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic [p_st_bits-1:0]          i_snk_data,
    input  logic                          i_snk_valid,
    output logic                          o_snk_ready,
    output logic [p_st_bits-1:0]          o_src_data,
    output logic                          o_src_valid,
    input  logic                          i_src_ready,
    output logic [p_fifo_length_log2:0]   o_level,
    output logic                          o_almost_full,
    output logic                          o_almost_empty,
    output logic [p_fifo_length_log2:0]   o_peak
);

    localparam int unsigned AW = p_fifo_length_log2;
    localparam int unsigned PW = p_fifo_length_log2 + 1;

    if (!thresholds_ok(p_fifo_length, p_fifo_length_log2, p_almost_full, p_almost_empty)) begin : g_param_check
        $error("stream_fifo_th: illegal depth or flag threshold parameters");
    end

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        level_nxt;
    logic [PW-1:0]        peak_nxt;
    logic [p_st_bits-1:0] rd_data;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 mem_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready never looks at i_src_ready, so a pop cannot free a slot in the same cycle.
    assign o_snk_ready = !full && !i_flush;
    assign push        = i_snk_valid && o_snk_ready;

    fifo_ram #(
        .p_width     (p_st_bits),
        .p_depth     (p_fifo_length),
        .p_addr_bits (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (i_snk_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

`ifdef STREAM_FIFO_OREG_EN
    logic                 oreg_valid;
    logic [p_st_bits-1:0] oreg_data;

    assign pop    = oreg_valid && i_src_ready && !i_flush && rst;
    // Refill whenever the output register is free or being emptied this cycle.
    assign mem_rd = !empty && (!oreg_valid || pop) && !i_flush;

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            oreg_valid <= 1'b0;
            oreg_data  <= '0;
        end else if (mem_rd) begin
            oreg_valid <= 1'b1;
            oreg_data  <= rd_data;
        end else if (pop) begin
            oreg_valid <= 1'b0;
        end
    end

    assign o_src_valid = oreg_valid;
    assign o_src_data  = oreg_data;
`else
    // Valid is masked during reset so nothing is delivered in the reset cycle.
    assign o_src_valid = !empty && !i_flush && rst;
    assign pop         = o_src_valid && i_src_ready;
    assign mem_rd      = pop;
    assign o_src_data  = o_src_valid ? rd_data : '0;
`endif

    always_comb begin
        level_nxt = o_level;
        if (i_flush) begin
            level_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_nxt = o_level + PW'(1);
                2'b01:   level_nxt = o_level - PW'(1);
                default: level_nxt = o_level;
            endcase
        end
        peak_nxt = (level_nxt > o_peak) ? level_nxt : o_peak;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_level        <= '0;
            o_peak         <= '0;
            o_almost_full  <= RST_ALMOST_FULL;
            o_almost_empty <= RST_ALMOST_EMPTY;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (mem_rd) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            o_level        <= level_nxt;
            o_almost_full  <= (level_nxt >= PW'(p_almost_full));
            o_almost_empty <= (level_nxt <= PW'(p_almost_empty));
            o_peak         <= peak_nxt;
        end
    end

endmodule

// File: tb/tb_stream_fifo_th.sv
// Scoreboard bench for stream_fifo_th: directed test-plan phases followed by randomized traffic.
module tb_stream_fifo_th;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LOG2  = 3;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [W-1:0]  snk_data;
    logic          snk_valid;
    logic          snk_ready;
    logic [W-1:0]  src_data;
    logic          src_valid;
    logic          src_ready;
    logic [LOG2:0] level;
    logic          almost_full;
    logic          almost_empty;
    logic [LOG2:0] peak;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_pop    = 0;
    bit            chk_en   = 1'b0;
    bit            push_fired = 1'b0;

    logic [W-1:0]  mq[$];
    logic [W-1:0]  sb[$];
    int            m_peak = 0;

    stream_fifo_th #(
        .p_st_bits          (W),
        .p_fifo_length      (DEPTH),
        .p_fifo_length_log2 (LOG2),
        .p_almost_full      (AF),
        .p_almost_empty     (AE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (flush),
        .i_snk_data     (snk_data),
        .i_snk_valid    (snk_valid),
        .o_snk_ready    (snk_ready),
        .o_src_data     (src_data),
        .o_src_valid    (src_valid),
        .i_src_ready    (src_ready),
        .o_level        (level),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_peak         (peak)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor pops the scoreboard on every DUT handshake; the reference model then advances.
    always @(posedge clk) begin
        logic [W-1:0] exp_word;
        bit           m_push;
        bit           m_pop;
        if (chk_en && src_valid === 1'b1 && src_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got a word %0h expected none at %0t", src_data, $time);
            end else begin
                exp_word = sb.pop_front();
                check("order", src_data, exp_word);
            end
        end
        m_push = 1'b0;
        if (!rst) begin
            mq.delete();
            sb.delete();
            m_peak = 0;
        end else if (flush) begin
            mq.delete();
            sb.delete();
        end else begin
            m_pop  = (mq.size() > 0) && src_ready;
            m_push = snk_valid && (mq.size() < DEPTH);
            if (m_pop) begin
                void'(mq.pop_front());
            end
            if (m_push) begin
                mq.push_back(snk_data);
                sb.push_back(snk_data);
            end
        end
        if (mq.size() > m_peak) begin
            m_peak = mq.size();
        end
        push_fired = m_push;
    end

    // Cycle-by-cycle comparison of every status output against the model.
    always @(negedge clk) begin
        int sz;
        bit exp_valid;
        if (chk_en) begin
            sz        = mq.size();
            exp_valid = (sz > 0) && !flush && rst;
            check("level", level, sz);
            check("snk_ready", snk_ready, (sz < DEPTH) && !flush);
            check("src_valid", src_valid, exp_valid);
            if (exp_valid) begin
                check("src_data", src_data, mq[0]);
            end
            check("almost_full", almost_full, sz >= AF);
            check("almost_empty", almost_empty, sz <= AE);
            check("peak", peak, m_peak);
        end
    end

    task automatic push_words(input int n, input logic [W-1:0] base);
        src_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            snk_valid = 1'b1;
            snk_data  = base + W'(i);
            tick();
        end
        snk_valid = 1'b0;
    endtask

    task automatic drain();
        snk_valid = 1'b0;
        src_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        src_ready = 1'b0;
    endtask

    initial begin
        int pops_before;
        int vprob;
        int rprob;
        rst       = 1'b0;
        flush     = 1'b0;
        snk_valid = 1'b0;
        snk_data  = '0;
        src_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rst_level", level, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_snk_ready", snk_ready, 1);
        check("rst_src_valid", src_valid, 0);

        // Fill with 0..7, then offer a 9th word that must be refused.
        push_words(DEPTH, 0);
        snk_valid = 1'b1;
        snk_data  = W'(DEPTH);
        tick();
        tick();
        snk_valid = 1'b0;
        check("fill_level", level, DEPTH);
        check("fill_snk_ready", snk_ready, 0);
        check("fill_almost_full", almost_full, 1);
        check("fill_peak", peak, DEPTH);

        pops_before = n_pop;
        drain();
        check("drain_count", n_pop - pops_before, DEPTH);
        check("drain_src_valid", src_valid, 0);
        check("drain_peak", peak, DEPTH);
        check("drain_almost_empty", almost_empty, 1);

        // Streaming at level 4 across two pointer wraps.
        push_words(4, 32'h100);
        snk_valid = 1'b1;
        src_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            snk_data = 32'h104 + W'(k);
            tick();
        end
        snk_valid = 1'b0;
        src_ready = 1'b0;
        check("stream_level", level, 4);
        drain();

        // Flush at level 5 with both handshakes requested.
        push_words(5, 32'h200);
        pops_before = n_pop;
        flush     = 1'b1;
        snk_valid = 1'b1;
        snk_data  = 32'hdead;
        src_ready = 1'b1;
        tick();
        flush     = 1'b0;
        snk_valid = 1'b0;
        src_ready = 1'b0;
        check("flush_no_pop", n_pop - pops_before, 0);
        check("flush_level", level, 0);
        check("flush_src_valid", src_valid, 0);
        check("flush_almost_empty", almost_empty, 1);
        check("flush_peak", peak, DEPTH);

        // Reset mid-stream at level 3 with the consumer ready.
        push_words(3, 32'h300);
        pops_before = n_pop;
        rst       = 1'b0;
        src_ready = 1'b1;
        tick();
        rst       = 1'b1;
        src_ready = 1'b0;
        check("midrst_no_pop", n_pop - pops_before, 0);
        check("midrst_level", level, 0);
        check("midrst_src_valid", src_valid, 0);
        check("midrst_src_data", src_data, 0);
        check("midrst_snk_ready", snk_ready, 1);
        check("midrst_almost_empty", almost_empty, 1);
        check("midrst_almost_full", almost_full, 0);
        check("midrst_peak", peak, 0);

        // Randomized traffic in segments of varying push/pop bias.
        for (int seg = 0; seg < 6; seg++) begin
            vprob = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 1 : 2);
            rprob = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 3 : 2);
            for (int c = 0; c < 500; c++) begin
                if (!(snk_valid && !push_fired)) begin
                    snk_valid = ($urandom_range(0, 3) < vprob);
                    snk_data  = $urandom;
                end
                src_ready = ($urandom_range(0, 3) < rprob);
                flush     = ($urandom_range(0, 49) == 0);
                rst       = ($urandom_range(0, 399) != 0);
                tick();
            end
        end
        rst       = 1'b1;
        flush     = 1'b0;
        snk_valid = 1'b0;
        drain();
        check("final_level", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
